fu_wb_arbiter: RTL and testbench

Write-back arbiter between the functional units (ALU, MEM, MUL, DIV, JUMP) and the register-file write port / scoreboard result bus. Each FU reports completion with a one-cycle `finish` pulse that it does not hold. This block therefore captures every result into a per-FU one-entry holding slot. It then grants exactly one slot per cycle to the single write-back bus, round-robin, and reports slot occupancy so issue logic can hold back a unit whose previous result has not yet retired.

---
 rtl/fu_wb_arbiter_if.sv | 27 ++
 rtl/fu_wb_arbiter.sv | 95 +++++++++
 tb/tb_fu_wb_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fu_wb_arbiter_if.sv
// Bundle between the functional units, the write-back arbiter and the result bus.
// The FU side drives results through master; the arbiter consumes them through slave.
interface fu_wb_arbiter_if #(
    parameter int N_FU = 5,
    parameter int DW   = 32,
    parameter int RW   = 5
);
    logic [N_FU-1:0]    fu_finish;
    logic [N_FU*DW-1:0] fu_res;
    logic [N_FU*RW-1:0] fu_rd;
    logic [N_FU-1:0]    slot_full;
    logic               wb_valid;
    logic [2:0]         wb_fu;
    logic [RW-1:0]      wb_rd;
    logic [DW-1:0]      wb_data;
    logic [N_FU-1:0]    overflow_err;

    modport master (
        output fu_finish, fu_res, fu_rd,
        input  slot_full, wb_valid, wb_fu, wb_rd, wb_data, overflow_err
    );

    modport slave (
        input  fu_finish, fu_res, fu_rd,
        output slot_full, wb_valid, wb_fu, wb_rd, wb_data, overflow_err
    );
endinterface

// File: rtl/fu_wb_arbiter.sv
// Write-back arbiter: one holding slot per functional unit, round-robin grant of a
// single slot per cycle onto the register-file write-back bus.
module fu_wb_arbiter #(
    parameter int N_FU = 5,
    parameter int DW   = 32,
    parameter int RW   = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    fu_wb_arbiter_if.slave bus
);

    logic [N_FU-1:0] full_vec;
    logic [N_FU-1:0] ovf_vec;
    logic [N_FU-1:0] granted;
    logic [RW-1:0]   rd_all   [N_FU];
    logic [DW-1:0]   data_all [N_FU];

    logic [2:0]      rr_ptr_reg;
    logic            grant_vld;
    logic [2:0]      grant_idx;
    int              idx;

    // Walk the search order backwards so the entry closest to rr_ptr wins last.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = N_FU - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_reg) + k) % N_FU;
            if (full_vec[idx]) begin
                grant_vld = 1'b1;
                grant_idx = 3'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_reg <= '0;
        end else if (grant_vld) begin
            rr_ptr_reg <= (grant_idx == 3'(N_FU - 1)) ? 3'd0 : grant_idx + 3'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_FU; gi++) begin : g_slot
            logic          full_reg;
            logic          ovf_reg;
            logic [RW-1:0] rd_reg;
            logic [DW-1:0] data_reg;
            logic          capture;
            logic          drop;

            assign granted[gi] = grant_vld && (grant_idx == 3'(gi));
            // A slot being drained this cycle can take a new result without loss.
            assign capture = bus.fu_finish[gi] && (!full_reg || granted[gi]);
            assign drop    = bus.fu_finish[gi] && full_reg && !granted[gi];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    full_reg <= 1'b0;
                    ovf_reg  <= 1'b0;
                    rd_reg   <= '0;
                    data_reg <= '0;
                end else begin
                    if (capture) begin
                        full_reg <= 1'b1;
                        rd_reg   <= bus.fu_rd[gi*RW +: RW];
                        data_reg <= bus.fu_res[gi*DW +: DW];
                    end else if (granted[gi]) begin
                        full_reg <= 1'b0;
                    end
                    if (drop) begin
                        ovf_reg <= 1'b1;
                    end
                end
            end

            assign full_vec[gi] = full_reg;
            assign ovf_vec[gi]  = ovf_reg;
            assign rd_all[gi]   = rd_reg;
            assign data_all[gi] = data_reg;
        end
    endgenerate

    assign bus.slot_full    = full_vec;
    assign bus.overflow_err = ovf_vec;
    assign bus.wb_valid     = grant_vld;
    assign bus.wb_fu        = grant_vld ? grant_idx : 3'd0;
    assign bus.wb_rd        = grant_vld ? rd_all[grant_idx] : '0;
    assign bus.wb_data      = grant_vld ? data_all[grant_idx] : '0;

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Directed bench for fu_wb_arbiter: reset, single grant, round-robin drain, wrap,
// overflow, back-to-back throughput and reset during activity.
module tb_fu_wb_arbiter;
    localparam int N_FU = 5;
    localparam int DW   = 32;
    localparam int RW   = 5;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    fu_wb_arbiter_if #(.N_FU(N_FU), .DW(DW), .RW(RW)) bus ();

    fu_wb_arbiter #(.N_FU(N_FU), .DW(DW), .RW(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.fu_finish = '0;
        bus.fu_res    = '0;
        bus.fu_rd     = '0;
    endtask

    task automatic fin(input int i, input logic [RW-1:0] rd, input logic [DW-1:0] data);
        bus.fu_finish[i]        = 1'b1;
        bus.fu_rd[i*RW +: RW]   = rd;
        bus.fu_res[i*DW +: DW]  = data;
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", bus.wb_valid); end
        n_checks++;
        if (bus.wb_fu !== 3'd0 || bus.wb_rd !== 5'd0 || bus.wb_data !== 32'd0) begin
            n_fail++; $display("FAIL reset_bus: got fu=%0d rd=%0d data=%h expected all 0", bus.wb_fu, bus.wb_rd, bus.wb_data);
        end
        n_checks++;
        if (bus.slot_full !== 5'b0 || bus.overflow_err !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got full=%b ovf=%b expected 0", bus.slot_full, bus.overflow_err);
        end
    endtask

    task automatic test_single_div();
        do_reset();
        fin(3, 5'd7, 32'h0000_0003);
        tick();
        clear_in();
        $display("txn single: fu=%0d rd=%0d data=%h", bus.wb_fu, bus.wb_rd, bus.wb_data);
        n_checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_fu !== 3'd3) begin
            n_fail++; $display("FAIL single_grant: got valid=%0b fu=%0d expected 1/3", bus.wb_valid, bus.wb_fu);
        end
        n_checks++;
        if (bus.wb_rd !== 5'd7 || bus.wb_data !== 32'd3) begin
            n_fail++; $display("FAIL single_payload: got rd=%0d data=%h expected 7/3", bus.wb_rd, bus.wb_data);
        end
        n_checks++;
        if (bus.slot_full !== 5'b01000) begin n_fail++; $display("FAIL single_full: got %b expected 01000", bus.slot_full); end
        tick();
        n_checks++;
        if (bus.wb_valid !== 1'b0 || bus.slot_full !== 5'b0) begin
            n_fail++; $display("FAIL single_drain: got valid=%0b full=%b expected 0/00000", bus.wb_valid, bus.slot_full);
        end
    endtask

    task automatic test_all_five();
        do_reset();
        for (int i = 0; i < N_FU; i++) fin(i, 5'(i + 1), 32'h100 + 32'(i));
        tick();
        clear_in();
        n_checks++;
        if (bus.slot_full !== 5'b11111) begin n_fail++; $display("FAIL all_full: got %b expected 11111", bus.slot_full); end
        for (int k = 0; k < N_FU; k++) begin
            $display("txn all: fu=%0d rd=%0d data=%h", bus.wb_fu, bus.wb_rd, bus.wb_data);
            n_checks++;
            if (bus.wb_valid !== 1'b1 || bus.wb_fu !== 3'(k) || bus.wb_rd !== 5'(k + 1) || bus.wb_data !== 32'h100 + 32'(k)) begin
                n_fail++;
                $display("FAIL all_grant%0d: got valid=%0b fu=%0d rd=%0d data=%h expected 1/%0d/%0d/%h",
                         k, bus.wb_valid, bus.wb_fu, bus.wb_rd, bus.wb_data, k, k + 1, 32'h100 + 32'(k));
            end
            tick();
        end
        n_checks++;
        if (bus.wb_valid !== 1'b0 || dut.rr_ptr_reg !== 3'd0) begin
            n_fail++; $display("FAIL all_end: got valid=%0b rr_ptr=%0d expected 0/0", bus.wb_valid, dut.rr_ptr_reg);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        fin(0, 5'd1, 32'h11);
        tick();
        clear_in();
        n_checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_fu !== 3'd0) begin
            n_fail++; $display("FAIL fair_first: got valid=%0b fu=%0d expected 1/0", bus.wb_valid, bus.wb_fu);
        end
        tick();
        fin(0, 5'd2, 32'h22);
        fin(4, 5'd3, 32'h44);
        tick();
        clear_in();
        $display("txn fair: fu=%0d rd=%0d data=%h", bus.wb_fu, bus.wb_rd, bus.wb_data);
        n_checks++;
        if (bus.wb_fu !== 3'd4 || bus.wb_rd !== 5'd3 || bus.wb_data !== 32'h44) begin
            n_fail++; $display("FAIL fair_jump: got fu=%0d rd=%0d data=%h expected 4/3/44", bus.wb_fu, bus.wb_rd, bus.wb_data);
        end
        tick();
        $display("txn fair: fu=%0d rd=%0d data=%h", bus.wb_fu, bus.wb_rd, bus.wb_data);
        n_checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_fu !== 3'd0 || bus.wb_rd !== 5'd2 || bus.wb_data !== 32'h22) begin
            n_fail++; $display("FAIL fair_alu: got valid=%0b fu=%0d rd=%0d data=%h expected 1/0/2/22",
                               bus.wb_valid, bus.wb_fu, bus.wb_rd, bus.wb_data);
        end
        tick();
        n_checks++;
        if (bus.wb_valid !== 1'b0 || dut.rr_ptr_reg !== 3'd1) begin
            n_fail++; $display("FAIL fair_end: got valid=%0b rr_ptr=%0d expected 0/1", bus.wb_valid, dut.rr_ptr_reg);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        fin(2, 5'd9, 32'h55);
        fin(0, 5'd1, 32'h10);
        tick();
        clear_in();
        n_checks++;
        if (bus.wb_fu !== 3'd0 || bus.wb_data !== 32'h10) begin
            n_fail++; $display("FAIL ovf_alu: got fu=%0d data=%h expected 0/10", bus.wb_fu, bus.wb_data);
        end
        fin(2, 5'd12, 32'hAA);
        tick();
        clear_in();
        n_checks++;
        if (bus.overflow_err !== 5'b00100) begin n_fail++; $display("FAIL ovf_flag: got %b expected 00100", bus.overflow_err); end
        $display("txn ovf: fu=%0d rd=%0d data=%h", bus.wb_fu, bus.wb_rd, bus.wb_data);
        n_checks++;
        if (bus.wb_fu !== 3'd2 || bus.wb_rd !== 5'd9 || bus.wb_data !== 32'h55) begin
            n_fail++; $display("FAIL ovf_keep: got fu=%0d rd=%0d data=%h expected 2/9/55", bus.wb_fu, bus.wb_rd, bus.wb_data);
        end
        tick();
        n_checks++;
        if (bus.wb_valid !== 1'b0 || bus.overflow_err !== 5'b00100) begin
            n_fail++; $display("FAIL ovf_sticky: got valid=%0b ovf=%b expected 0/00100", bus.wb_valid, bus.overflow_err);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        fin(0, 5'd1, 32'h1000);
        tick();
        for (int c = 1; c <= 10; c++) begin
            clear_in();
            if (c < 10) fin(0, 5'(c + 1), 32'h1000 + 32'(c));
            $display("txn b2b: fu=%0d rd=%0d data=%h", bus.wb_fu, bus.wb_rd, bus.wb_data);
            n_checks++;
            if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'(c) || bus.wb_data !== 32'h1000 + 32'(c - 1)) begin
                n_fail++; $display("FAIL b2b_%0d: got valid=%0b rd=%0d data=%h expected 1/%0d/%h",
                                   c, bus.wb_valid, bus.wb_rd, bus.wb_data, c, 32'h1000 + 32'(c - 1));
            end
            tick();
        end
        n_checks++;
        if (bus.wb_valid !== 1'b0 || bus.overflow_err !== 5'b0) begin
            n_fail++; $display("FAIL b2b_end: got valid=%0b ovf=%b expected 0/00000", bus.wb_valid, bus.overflow_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fin(1, 5'd4, 32'hA1);
        fin(2, 5'd5, 32'hA2);
        fin(3, 5'd6, 32'hA3);
        tick();
        clear_in();
        n_checks++;
        if (bus.slot_full !== 5'b01110) begin n_fail++; $display("FAIL mid_full: got %b expected 01110", bus.slot_full); end
        rst_n = 1'b0;
        fin(2, 5'd8, 32'hB2);
        fin(4, 5'd9, 32'hB4);
        tick();
        rst_n = 1'b1;
        clear_in();
        n_checks++;
        if (bus.wb_valid !== 1'b0 || bus.wb_fu !== 3'd0 || bus.wb_rd !== 5'd0 || bus.wb_data !== 32'd0) begin
            n_fail++; $display("FAIL mid_bus: got valid=%0b fu=%0d rd=%0d data=%h expected all 0",
                               bus.wb_valid, bus.wb_fu, bus.wb_rd, bus.wb_data);
        end
        n_checks++;
        if (bus.slot_full !== 5'b0 || bus.overflow_err !== 5'b0) begin
            n_fail++; $display("FAIL mid_flags: got full=%b ovf=%b expected 0/0", bus.slot_full, bus.overflow_err);
        end
        tick();
        n_checks++;
        if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL mid_lost: got valid=%0b expected 0", bus.wb_valid); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        clear_in();
        test_reset();
        test_single_div();
        test_all_five();
        test_fairness();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
